// File: rtl/mem_access_unit.sv
// Memory stage: steers stores, extracts and extends loads, rejects illegal or misaligned accesses; watchdog under MEM_TIMEOUT_EN.
// Latency: store accept->DONE 2 cycles, load accept->DONE 3 cycles minimum (plus ready/response wait).
// Backpressure: REQ holds request fields stable until d_req_ready; stall freezes upstream in REQ/WAIT.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [31:0]           ALU_result,
    input  logic [31:0]           store_data,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  bus_error,
    output logic                  d_req_valid,
    input  logic                  d_req_ready,
    output logic                  d_req_we,
    output logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic [31:0]           d_req_wdata,
    output logic [3:0]            d_req_be,
    input  logic                  d_rsp_valid,
    input  logic [31:0]           d_rsp_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic                  req_any, f3_ok, align_ok, illegal, legal;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic                  we_q;
    logic [3:0]            be_q, be_nxt;
    logic [31:0]           wdata_q, wdata_nxt;
    logic [31:0]           load_data_q, rsp_shift, rsp_ext;
    logic                  timed_out_q, timeout_hit;

    always_comb begin
        req_any = mem_read | mem_write;
        if (mem_write)
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            f3_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        case (funct3[1:0])
            2'b01:   align_ok = ~ALU_result[0];
            2'b10:   align_ok = (ALU_result[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        illegal = req_any & ((mem_read & mem_write) | ~f3_ok | ~align_ok);
        legal   = req_any & ~illegal;
    end

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = store_data;
        case (funct3[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << ALU_result[1:0];
                wdata_nxt = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_nxt    = ALU_result[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{store_data[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = store_data;
            end
        endcase
        if (!mem_write)
            wdata_nxt = '0;
    end

    always_comb begin
        rsp_shift = d_rsp_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  rsp_ext = {{24{rsp_shift[7]}}, rsp_shift[7:0]};
            3'b001:  rsp_ext = {{16{rsp_shift[15]}}, rsp_shift[15:0]};
            3'b100:  rsp_ext = {24'b0, rsp_shift[7:0]};
            3'b101:  rsp_ext = {16'b0, rsp_shift[15:0]};
            default: rsp_ext = rsp_shift;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Held at zero outside WAIT, so it is cleared on every entry to WAIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (state != WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 8'd1;
    end

    assign timeout_hit = (state == WAIT) && !d_rsp_valid &&
                         (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (legal) state_nxt = REQ;
            REQ:  if (d_req_ready) state_nxt = we_q ? DONE : WAIT;
            WAIT: if (d_rsp_valid || timeout_hit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (state == IDLE && legal) begin
                addr_q      <= {ALU_result[ADDR_WIDTH-1:2], 2'b00};
                off_q       <= ALU_result[1:0];
                f3_q        <= funct3;
                we_q        <= mem_write;
                be_q        <= be_nxt;
                wdata_q     <= wdata_nxt;
                timed_out_q <= 1'b0;
            end
            if (state == WAIT && d_rsp_valid) begin
                load_data_q <= rsp_ext;
            end else if (timeout_hit) begin
                load_data_q <= '0;
                timed_out_q <= 1'b1;
            end
        end
    end

    // IDLE-state outputs depend on live inputs, so gate them with reset to keep all outputs low in reset.
    always_comb begin
        stall       = 1'b0;
        misaligned  = 1'b0;
        load_valid  = 1'b0;
        bus_error   = 1'b0;
        d_req_valid = 1'b0;
        case (state)
            IDLE: begin
                stall      = reset & legal;
                misaligned = reset & illegal;
            end
            REQ: begin
                stall       = 1'b1;
                d_req_valid = 1'b1;
            end
            WAIT: stall = 1'b1;
            DONE: begin
                load_valid = ~we_q;
                bus_error  = timed_out_q;
            end
            default: stall = 1'b0;
        endcase
    end

    assign d_req_we    = we_q;
    assign d_req_addr  = addr_q;
    assign d_req_be    = be_q;
    assign d_req_wdata = wdata_q;
    assign load_data   = load_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and randomized accesses checked cycle by cycle against an arithmetic model.
module tb_mem_access_unit;
    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] ALU_result = '0, store_data = '0;
    logic [31:0] load_data;
    logic        load_valid, stall, misaligned, bus_error;
    logic        d_req_valid, d_req_we;
    logic        d_req_ready = 1'b0;
    logic [31:0] d_req_addr, d_req_wdata;
    logic [3:0]  d_req_be;
    logic        d_rsp_valid = 1'b0;
    logic [31:0] d_rsp_rdata = '0;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .ALU_result(ALU_result), .store_data(store_data),
        .load_data(load_data), .load_valid(load_valid), .stall(stall),
        .misaligned(misaligned), .bus_error(bus_error),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata)
    );

    // Flag vector order: {stall, d_req_valid, load_valid, misaligned, bus_error}
    function automatic logic [4:0] flags();
        return {stall, d_req_valid, load_valid, misaligned, bus_error};
    endfunction

    function automatic bit model_illegal(logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
        int nbytes;
        if (rd && wr) return 1'b1;
        if (wr && f3 > 3'd2) return 1'b1;
        if (rd && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
        nbytes = 1 << f3[1:0];
        return (a % nbytes) != 0;
    endfunction

    function automatic logic [3:0] model_be(logic [2:0] f3, logic [31:0] a);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
        if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rdata);
        longint v;
        int nbits;
        nbits = 8 << f3[1:0];
        v = longint'(rdata >> (8 * (a % 4)));
        if (nbits < 32) begin
            v = v & ((64'd1 << nbits) - 1);
            if (!f3[2] && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
        end
        return v[31:0];
    endfunction

    task automatic clear_inputs();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'($urandom);
        ALU_result = $urandom;
        store_data = $urandom;
    endtask

    // Drives one access from the IDLE cycle through DONE, checking every cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                             input int rdy_wait, input int rsp_wait, input string name);
        bit   ill;
        int   stalls;
        logic [4:0] exp_f;
        @(negedge clock);
        mem_read = rd; mem_write = wr; funct3 = f3; ALU_result = a; store_data = d;
        d_req_ready = 1'($urandom); d_rsp_valid = 1'($urandom); d_rsp_rdata = $urandom;
        #1;
        ill = model_illegal(rd, wr, f3, a);
        exp_f = ill ? 5'b00010 : 5'b10000;
        checks++;
        if (flags() !== exp_f) begin
            failures++;
            $display("FAIL %s accept flags got=%b exp=%b", name, flags(), exp_f);
        end
        if (ill) begin
            @(negedge clock);
            clear_inputs();
            d_rsp_valid = 1'b0;
            #1;
            checks++;
            if (flags() !== 5'b00000) begin
                failures++;
                $display("FAIL %s after_illegal flags got=%b exp=00000", name, flags());
            end
            return;
        end
        stalls = 1;
        @(negedge clock);
        clear_inputs();
        for (int k = 0; k <= rdy_wait; k++) begin
            d_req_ready = (k == rdy_wait);
            d_rsp_valid = 1'($urandom);
            d_rsp_rdata = $urandom;
            #1;
            if (stall) stalls++;
            checks++;
            if (flags() !== 5'b11000 || d_req_we !== wr || d_req_addr !== (a & ~32'd3)) begin
                failures++;
                $display("FAIL %s req flags=%b we=%b addr=%h exp flags=11000 we=%b addr=%h",
                         name, flags(), d_req_we, d_req_addr, wr, a & ~32'd3);
            end
            if (wr) begin
                checks++;
                if (d_req_be !== model_be(f3, a) || d_req_wdata !== model_wdata(f3, d)) begin
                    failures++;
                    $display("FAIL %s store be=%b wdata=%h exp be=%b wdata=%h",
                             name, d_req_be, d_req_wdata, model_be(f3, a), model_wdata(f3, d));
                end
            end
            @(negedge clock);
        end
        d_req_ready = 1'($urandom);
        if (!wr) begin
            for (int k = 0; k <= rsp_wait; k++) begin
                d_rsp_valid = (k == rsp_wait);
                d_rsp_rdata = (k == rsp_wait) ? rdata : $urandom;
                #1;
                if (stall) stalls++;
                checks++;
                if (flags() !== 5'b10000) begin
                    failures++;
                    $display("FAIL %s wait flags got=%b exp=10000", name, flags());
                end
                @(negedge clock);
            end
        end
        d_rsp_valid = 1'($urandom);
        d_rsp_rdata = $urandom;
        #1;
        exp_f = {2'b00, ~wr, 2'b00};
        checks++;
        if (flags() !== exp_f) begin
            failures++;
            $display("FAIL %s done flags got=%b exp=%b", name, flags(), exp_f);
        end
        if (!wr) begin
            checks++;
            if (load_data !== model_load(f3, a, rdata)) begin
                failures++;
                $display("FAIL %s load_data got=%h exp=%h", name, load_data, model_load(f3, a, rdata));
            end
        end
        checks++;
        if (stalls !== (wr ? 2 + rdy_wait : 3 + rdy_wait + rsp_wait)) begin
            failures++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stalls,
                     wr ? 2 + rdy_wait : 3 + rdy_wait + rsp_wait);
        end
        d_rsp_valid = 1'b0;
    endtask

    task automatic idle_cycle(input string name);
        @(negedge clock);
        clear_inputs();
        d_rsp_valid = 1'b0;
        #1;
        checks++;
        if (flags() !== 5'b00000) begin
            failures++;
            $display("FAIL %s idle flags got=%b exp=00000", name, flags());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_read = 1'b1; funct3 = 3'b010; ALU_result = 32'h100;
        d_rsp_valid = 1'b1; d_rsp_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (flags() !== 5'b0 || d_req_we !== 1'b0 || d_req_addr !== 32'h0 ||
            d_req_be !== 4'h0 || d_req_wdata !== 32'h0 || load_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_state flags=%b addr=%h be=%b wdata=%h load_data=%h exp all zero",
                     flags(), d_req_addr, d_req_be, d_req_wdata, load_data);
        end
        @(negedge clock);
        clear_inputs();
        d_rsp_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_loads();
        do_access(1, 0, 3'b000, 32'h1003, 32'h0, 32'h8000_0000, 0, 0, "lb_1003");
        do_access(1, 0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_1234, 0, 0, "lhu_2002");
        do_access(1, 0, 3'b001, 32'h2002, 32'h0, 32'hBEEF_1234, 0, 0, "lh_2002");
        do_access(1, 0, 3'b100, 32'h3001, 32'h0, 32'h0000_F500, 1, 2, "lbu_3001");
        do_access(1, 0, 3'b010, 32'h4000, 32'h0, 32'hCAFE_F00D, 0, 1, "lw_4000");
        idle_cycle("loads");
    endtask

    task automatic test_stores();
        do_access(0, 1, 3'b000, 32'h11, 32'hAB, 32'h0, 0, 0, "sb_11");
        do_access(0, 1, 3'b001, 32'h12, 32'h1234_5678, 32'h0, 0, 0, "sh_12");
        do_access(0, 1, 3'b010, 32'h20, 32'h8765_4321, 32'h0, 0, 0, "sw_20");
        idle_cycle("stores");
    endtask

    task automatic test_misaligned();
        do_access(1, 0, 3'b010, 32'h6, 32'h0, 32'h0, 0, 0, "lw_6");
        do_access(1, 1, 3'b010, 32'h8, 32'h0, 32'h0, 0, 0, "both_strobes");
        do_access(1, 0, 3'b101, 32'h5, 32'h0, 32'h0, 0, 0, "lhu_odd");
        do_access(0, 1, 3'b001, 32'h3, 32'h0, 32'h0, 0, 0, "sh_odd");
        do_access(1, 0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0, "load_f3_011");
        do_access(0, 1, 3'b100, 32'h0, 32'h0, 32'h0, 0, 0, "store_f3_100");
    endtask

    task automatic test_backpressure();
        do_access(0, 1, 3'b000, 32'h57, 32'h5A, 32'h0, 4, 0, "sb_ready_low");
        do_access(1, 0, 3'b001, 32'h9A, 32'h0, 32'h1357_9BDF, 5, 3, "lh_ready_low");
        idle_cycle("backpressure");
    endtask

    task automatic test_back_to_back();
        do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'h0123_4567, 0, 0, "b2b_lw");
        do_access(0, 1, 3'b010, 32'h104, 32'hFEDC_BA98, 32'h0, 0, 0, "b2b_sw");
        do_access(1, 0, 3'b000, 32'h102, 32'h0, 32'h00FF_0000, 0, 0, "b2b_lb");
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        mem_read = 1'b1; funct3 = 3'b010; ALU_result = 32'h200; d_req_ready = 1'b1;
        @(negedge clock);
        clear_inputs();
        @(negedge clock);
        d_rsp_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (flags() !== 5'b0 || d_req_addr !== 32'h0 || d_req_be !== 4'h0 ||
            d_req_wdata !== 32'h0 || d_req_we !== 1'b0 || load_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid flags=%b addr=%h be=%b load_data=%h exp all zero",
                     flags(), d_req_addr, d_req_be, load_data);
        end
        @(negedge clock);
        reset = 1'b1;
        d_rsp_valid = 1'b1;
        d_rsp_rdata = 32'h7777_7777;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            d_rsp_valid = 1'b0;
            #1;
            checks++;
            if (flags() !== 5'b0 || load_data !== 32'h0) begin
                failures++;
                $display("FAIL stray_rsp flags=%b load_data=%h exp 00000/0", flags(), load_data);
            end
        end
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        int waits;
        bit done;
        @(negedge clock);
        mem_read = 1'b1; funct3 = 3'b010; ALU_result = 32'h40; d_req_ready = 1'b1;
        @(negedge clock);
        clear_inputs();
        @(negedge clock);
        d_rsp_valid = 1'b0;
        waits = 0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            #1;
            if (load_valid) done = 1'b1;
            else begin
                waits++;
                @(negedge clock);
            end
        end
        checks++;
        if (!done || waits !== TIMEOUT || flags() !== 5'b00101 || load_data !== 32'h0) begin
            failures++;
            $display("FAIL timeout waits=%0d flags=%b load_data=%h exp waits=%0d flags=00101 data=0",
                     waits, flags(), load_data, TIMEOUT);
        end
        idle_cycle("timeout");
`else
        do_access(1, 0, 3'b010, 32'h40, 32'h0, 32'hA5A5_5A5A, 0, 3 * TIMEOUT, "no_watchdog");
        idle_cycle("no_watchdog");
`endif
    endtask

    task automatic test_random();
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            rd = 1'($urandom);
            wr = rd ? ($urandom_range(0, 7) == 0) : 1'b1;
            f3 = 3'($urandom);
            a  = $urandom;
            do_access(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 3), "random");
            if ($urandom_range(0, 2) == 0) idle_cycle("random");
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
